// File: rtl/regfile_pkg.sv
// Shared constants and write-port payload type for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam int unsigned DEFAULT_NUM_REGS = 32;
  localparam int unsigned DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

  localparam int unsigned WP0 = 0;
  localparam int unsigned WP1 = 1;

  typedef struct packed {
    logic                      en;
    logic                      clr;
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy flops: a new producer (sb_set) wins over a same-cycle clearing write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          wr_en,
  input  logic [1:0]          wr_clr,
  input  logic [2*ADDR_W-1:0] wr_addr,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_addr,
  output logic [NUM_REGS-1:0] set_vec_c,
  output logic [NUM_REGS-1:0] clr_vec_c,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    set_vec_c = '0;
    clr_vec_c = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      set_vec_c[r] = sb_set && (sb_addr == ADDR_W'(r)) && !(ZERO_REG && (r == 0));
      for (int unsigned k = 0; k < 2; k++) begin
        if (wr_en[k] && wr_clr[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          clr_vec_c[r] = 1'b1;
        end
      end
    end
    busy_d = set_vec_c | (busy_q & ~clr_vec_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised writes (port 1 wins),
// optional write-to-read bypass, hardwired zero register and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDR_W-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic [1:0]               wr_clr,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be 1..4");
  end
  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
    $error("regfile_mp: NUM_REGS must be a power of two >= 2");
  end

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];

  logic [ADDR_W-1:0] wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              wr_ok0_c, wr_ok1_c;
  logic [NUM_REGS-1:0] set_vec_c, clr_vec_c;

  assign wa0 = wr_addr[WP0*ADDR_W +: ADDR_W];
  assign wa1 = wr_addr[WP1*ADDR_W +: ADDR_W];
  assign wd0 = wr_data[WP0*DATA_W +: DATA_W];
  assign wd1 = wr_data[WP1*DATA_W +: DATA_W];
  assign wr_ok0_c = wr_en[WP0] && !(ZERO_REG && (wa0 == '0));
  assign wr_ok1_c = wr_en[WP1] && !(ZERO_REG && (wa1 == '0));

  // Port 1 is applied last so it overwrites port 0 on an address collision.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      rf_d[r] = rf_q[r];
    end
    if (wr_ok0_c) rf_d[wa0] = wd0;
    if (wr_ok1_c) rf_d[wa1] = wd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        rf_q[r] <= rf_d[r];
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_clr    (wr_clr),
    .wr_addr   (wr_addr),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr),
    .set_vec_c (set_vec_c),
    .clr_vec_c (clr_vec_c),
    .busy_vec  (busy_vec)
  );

  // Read ports: storage, then bypass (port 1 last for priority), then zero override.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_data[p*DATA_W +: DATA_W] = rf_q[rd_addr[p*ADDR_W +: ADDR_W]];
      if (BYPASS) begin
        if (wr_en[WP0] && (wa0 == rd_addr[p*ADDR_W +: ADDR_W])) rd_data[p*DATA_W +: DATA_W] = wd0;
        if (wr_en[WP1] && (wa1 == rd_addr[p*ADDR_W +: ADDR_W])) rd_data[p*DATA_W +: DATA_W] = wd1;
      end
      if (ZERO_REG && (rd_addr[p*ADDR_W +: ADDR_W] == '0)) rd_data[p*DATA_W +: DATA_W] = '0;
      rd_busy[p] = busy_vec[rd_addr[p*ADDR_W +: ADDR_W]];
      if (BYPASS && clr_vec_c[rd_addr[p*ADDR_W +: ADDR_W]]
          && !set_vec_c[rd_addr[p*ADDR_W +: ADDR_W]]) begin
        rd_busy[p] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed checks on default and no-bypass register files plus a randomised sweep on a wide variant.
module tb_regfile_mp;

  localparam int unsigned SWEEP_CYCLES = 10000;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, nb_rd_data;
  logic [1:0]  rd_busy, nb_rd_busy;
  logic [1:0]  wr_en, wr_clr;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [31:0] busy_vec, nb_busy_vec;

  logic [15:0]  s_rd_addr;
  logic [255:0] s_rd_data;
  logic [3:0]   s_rd_busy;
  logic [1:0]   s_wr_en, s_wr_clr;
  logic [7:0]   s_wr_addr;
  logic [127:0] s_wr_data;
  logic         s_sb_set;
  logic [3:0]   s_sb_addr;
  logic [15:0]  s_busy_vec;

  int total;
  int bad;

  regfile_mp u_dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(busy_vec)
  );

  regfile_mp #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(nb_busy_vec)
  );

  regfile_mp #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4)) u_sw (
    .clk(clk), .reset(reset), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_clr(s_wr_clr),
    .sb_set(s_sb_set), .sb_addr(s_sb_addr), .busy_vec(s_busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_clr = '0; wr_addr = '0; wr_data = '0;
    sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic drive_wr(input int k, input logic [4:0] a, input logic [31:0] d, input logic clr);
    wr_en[k] = 1'b1;
    wr_clr[k] = clr;
    wr_addr[k*5 +: 5] = a;
    wr_data[k*32 +: 32] = d;
  endtask

  task automatic test_reset();
    rd_addr = {5'd0, 5'd5};
    #1;
    total++; if (rd_data !== 64'h0) begin bad++; $display("FAIL por_rd got=%h exp=0", rd_data); end
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL por_busy got=%h exp=0", busy_vec); end
    @(posedge clk); #1;
    reset = 1'b0;
    drive_wr(0, 5'd5, 32'hDEADBEEF, 1'b0);
    sb_set = 1'b1; sb_addr = 5'd2;
    tick(); idle(); #1;
    total++; if (rd_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_rst_rd got=%h exp=deadbeef", rd_data[31:0]); end
    total++; if (busy_vec !== 32'h4) begin bad++; $display("FAIL pre_rst_busy got=%h exp=4", busy_vec); end
    #2; reset = 1'b1; #1;
    total++; if (rd_data !== 64'h0) begin bad++; $display("FAIL mid_rst_rd got=%h exp=0", rd_data); end
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL mid_rst_busy got=%h exp=0", busy_vec); end
    drive_wr(0, 5'd5, 32'h55, 1'b0);
    sb_set = 1'b1; sb_addr = 5'd5;
    tick(); idle(); #1;
    reset = 1'b0;
    total++; if (rd_data[31:0] !== 32'h0 || busy_vec !== 32'h0) begin
      bad++; $display("FAIL held_rst got=%h/%h exp=0/0", rd_data[31:0], busy_vec); end
    tick();
    total++; if (rd_data[31:0] !== 32'h0 || nb_rd_data[31:0] !== 32'h0) begin
      bad++; $display("FAIL post_rst_r5 got=%h/%h exp=0/0", rd_data[31:0], nb_rd_data[31:0]); end
  endtask

  task automatic test_dual_write();
    drive_wr(0, 5'd3, 32'h11, 1'b0);
    drive_wr(1, 5'd7, 32'h22, 1'b0);
    tick(); idle();
    rd_addr = {5'd7, 5'd3}; #1;
    total++; if (rd_data !== {32'h22, 32'h11}) begin bad++; $display("FAIL dual_rd got=%h exp=%h", rd_data, {32'h22, 32'h11}); end
    total++; if (nb_rd_data !== {32'h22, 32'h11}) begin bad++; $display("FAIL dual_rd_nb got=%h exp=%h", nb_rd_data, {32'h22, 32'h11}); end
    drive_wr(0, 5'd9, 32'hAA, 1'b0);
    drive_wr(1, 5'd9, 32'hBB, 1'b0);
    rd_addr = {5'd9, 5'd9}; #1;
    total++; if (rd_data !== {32'hBB, 32'hBB}) begin bad++; $display("FAIL coll_bypass got=%h exp=bb/bb", rd_data); end
    total++; if (nb_rd_data !== 64'h0) begin bad++; $display("FAIL coll_nb_old got=%h exp=0", nb_rd_data); end
    tick(); idle(); #1;
    total++; if (rd_data !== {32'hBB, 32'hBB}) begin bad++; $display("FAIL coll_rd got=%h exp=bb/bb", rd_data); end
    total++; if (nb_rd_data !== {32'hBB, 32'hBB}) begin bad++; $display("FAIL coll_rd_nb got=%h exp=bb/bb", nb_rd_data); end
  endtask

  task automatic test_bypass();
    rd_addr = {5'd3, 5'd4};
    drive_wr(1, 5'd4, 32'h1234, 1'b0);
    #1;
    total++; if (rd_data[31:0] !== 32'h1234) begin bad++; $display("FAIL byp_same got=%h exp=1234", rd_data[31:0]); end
    total++; if (nb_rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL nobyp_same got=%h exp=0", nb_rd_data[31:0]); end
    total++; if (rd_data[63:32] !== 32'h11) begin bad++; $display("FAIL byp_other got=%h exp=11", rd_data[63:32]); end
    tick(); idle(); #1;
    total++; if (nb_rd_data[31:0] !== 32'h1234) begin bad++; $display("FAIL nobyp_next got=%h exp=1234", nb_rd_data[31:0]); end
    total++; if (rd_data[31:0] !== 32'h1234) begin bad++; $display("FAIL byp_next got=%h exp=1234", rd_data[31:0]); end
  endtask

  task automatic test_zero();
    rd_addr = {5'd0, 5'd0};
    drive_wr(0, 5'd0, 32'hFFFFFFFF, 1'b0);
    drive_wr(1, 5'd0, 32'hFFFFFFFF, 1'b1);
    sb_set = 1'b1; sb_addr = 5'd0;
    #1;
    total++; if (rd_data !== 64'h0) begin bad++; $display("FAIL zero_same got=%h exp=0", rd_data); end
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL zero_busy_same got=%b exp=00", rd_busy); end
    tick(); idle(); #1;
    total++; if (rd_data !== 64'h0 || nb_rd_data !== 64'h0) begin
      bad++; $display("FAIL zero_next got=%h/%h exp=0/0", rd_data, nb_rd_data); end
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL zero_bv got=%h exp=0", busy_vec); end
  endtask

  task automatic test_scoreboard();
    rd_addr = {5'd0, 5'd6};
    sb_set = 1'b1; sb_addr = 5'd6; #1;
    total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_pre got=%b exp=0", rd_busy[0]); end
    tick(); idle(); #1;
    total++; if (busy_vec !== 32'h40) begin bad++; $display("FAIL sb_set got=%h exp=40", busy_vec); end
    total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_rdbusy got=%b exp=1", rd_busy[0]); end
    drive_wr(0, 5'd6, 32'h66, 1'b1);
    sb_set = 1'b1; sb_addr = 5'd6; #1;
    total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_setwin_same got=%b exp=1", rd_busy[0]); end
    tick(); idle(); #1;
    total++; if (busy_vec !== 32'h40) begin bad++; $display("FAIL sb_setwin got=%h exp=40", busy_vec); end
    drive_wr(0, 5'd6, 32'h67, 1'b1); #1;
    total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_clr_byp got=%b exp=0", rd_busy[0]); end
    total++; if (nb_rd_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_clr_nobyp got=%b exp=1", nb_rd_busy[0]); end
    tick(); idle(); #1;
    total++; if (busy_vec !== 32'h0 || nb_busy_vec !== 32'h0) begin
      bad++; $display("FAIL sb_clr got=%h/%h exp=0/0", busy_vec, nb_busy_vec); end
    total++; if (rd_data[31:0] !== 32'h67) begin bad++; $display("FAIL sb_clr_data got=%h exp=67", rd_data[31:0]); end
    sb_set = 1'b1; sb_addr = 5'd10; tick();
    sb_addr = 5'd11; tick(); idle();
    drive_wr(0, 5'd10, 32'h1, 1'b1);
    drive_wr(1, 5'd11, 32'h2, 1'b0);
    tick(); idle(); #1;
    total++; if (busy_vec !== 32'h800) begin bad++; $display("FAIL sb_perport got=%h exp=800", busy_vec); end
  endtask

  task automatic test_sweep();
    logic [63:0] m_mem [16];
    logic [15:0] m_busy;
    logic [63:0] n_mem [16];
    logic [15:0] n_busy;
    logic [63:0] e_data;
    logic        e_busy, clr_hit, set_hit;
    logic [3:0]  a, wa0, wa1;
    int          errs;
    errs = 0;
    for (int r = 0; r < 16; r++) m_mem[r] = '0;
    m_busy = '0;
    for (int i = 0; i < SWEEP_CYCLES; i++) begin
      s_wr_en   = 2'($urandom);
      s_wr_clr  = 2'($urandom);
      s_wr_addr = 8'($urandom);
      s_wr_data = {$urandom, $urandom, $urandom, $urandom};
      s_sb_set  = 1'($urandom);
      s_sb_addr = 4'($urandom);
      s_rd_addr = 16'($urandom);
      wa0 = s_wr_addr[3:0];
      wa1 = s_wr_addr[7:4];
      #1;
      for (int p = 0; p < 4; p++) begin
        a = s_rd_addr[p*4 +: 4];
        e_data = m_mem[a];
        if (s_wr_en[0] && wa0 == a) e_data = s_wr_data[63:0];
        if (s_wr_en[1] && wa1 == a) e_data = s_wr_data[127:64];
        if (a == 4'd0) e_data = '0;
        clr_hit = (s_wr_en[0] && s_wr_clr[0] && wa0 == a) || (s_wr_en[1] && s_wr_clr[1] && wa1 == a);
        set_hit = s_sb_set && s_sb_addr == a && a != 4'd0;
        e_busy = (clr_hit && !set_hit) ? 1'b0 : m_busy[a];
        total++;
        if (s_rd_data[p*64 +: 64] !== e_data || s_rd_busy[p] !== e_busy) begin
          bad++; errs++;
          if (errs <= 10) $display("FAIL sweep_rd cyc=%0d port=%0d got=%h/%b exp=%h/%b",
                                   i, p, s_rd_data[p*64 +: 64], s_rd_busy[p], e_data, e_busy);
        end
      end
      for (int r = 0; r < 16; r++) n_mem[r] = m_mem[r];
      if (s_wr_en[0] && wa0 != 4'd0) n_mem[wa0] = s_wr_data[63:0];
      if (s_wr_en[1] && wa1 != 4'd0) n_mem[wa1] = s_wr_data[127:64];
      n_busy = m_busy;
      if (s_wr_en[0] && s_wr_clr[0]) n_busy[wa0] = 1'b0;
      if (s_wr_en[1] && s_wr_clr[1]) n_busy[wa1] = 1'b0;
      if (s_sb_set && s_sb_addr != 4'd0) n_busy[s_sb_addr] = 1'b1;
      tick();
      for (int r = 0; r < 16; r++) m_mem[r] = n_mem[r];
      m_busy = n_busy;
      total++;
      if (s_busy_vec !== m_busy) begin
        bad++; errs++;
        if (errs <= 10) $display("FAIL sweep_busy cyc=%0d got=%h exp=%h", i, s_busy_vec, m_busy);
      end
    end
    s_wr_en = '0; s_wr_clr = '0; s_sb_set = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    rd_addr = '0;
    idle();
    s_rd_addr = '0; s_wr_en = '0; s_wr_clr = '0; s_wr_addr = '0;
    s_wr_data = '0; s_sb_set = 1'b0; s_sb_addr = '0;
    #2;
    test_reset();
    test_dual_write();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS datapath, successor to the single-write, dual-read register memory. It provides NUM_RD combinational read ports, two prioritised synchronous write ports, optional same-cycle write-to-read bypass, and a hardwired zero register. It also keeps a per-register busy scoreboard that the issue logic uses to detect pending writes.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (power of two, ≥ 2)
- NUM_RD, 2, number of read ports (1..4)
- ADDR_W, $clog2(NUM_REGS), register address width (derived; do not override)
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears every register and every busy bit
- rd_addr  in  NUM_RD×ADDR_W  read address per port
- rd_data  out  NUM_RD×DATA_W  read data per port (combinational)
- rd_busy  out  NUM_RD  busy bit of the addressed register per port (combinational)
- wr_en  in  2  write enable, ports 0 and 1
- wr_addr  in  2×ADDR_W  write address per write port
- wr_data  in  2×DATA_W  write data per write port
- wr_clr  in  2  when high with wr_en, the write also clears the busy bit of wr_addr
- sb_set  in  1  mark register sb_addr busy (pending producer issued)
- sb_addr  in  ADDR_W  scoreboard set address
- busy_vec  out  NUM_REGS  full scoreboard, registered

## Operation
- Storage: NUM_REGS × DATA_W flops and NUM_REGS busy flops. Reset values: all registers 0, busy_vec 0, so rd_data = 0 and rd_busy = 0 for every address.
- Write: on a rising edge with wr_en[k] high, RF[wr_addr[k]] ← wr_data[k].
- Write-write collision (both enabled, same address): port 1 wins, and port 0's data is discarded. Busy clear is the OR of the two ports' wr_clr.
- Read: rd_data[p] = RF[rd_addr[p]] with no enable and no latency.
- Bypass (BYPASS=1): if wr_en[k] is high and wr_addr[k] == rd_addr[p], rd_data[p] = wr_data[k]. Port 1 has priority over port 0. With BYPASS=0, reads return the pre-edge contents.
- Zero register (ZERO_REG=1): writes to address 0 are dropped, rd_data is 0 for address 0 (including bypass), and sb_set to address 0 is ignored.
- Scoreboard, per register r, next state:
  - if sb_set && sb_addr==r, busy ← 1 (set wins over a same-cycle clear, because a new producer supersedes the old one);
  - else if any port k has wr_en[k] && wr_clr[k] && wr_addr[k]==r, busy ← 0;
  - else busy holds.
- rd_busy[p] = busy_vec[rd_addr[p]]. With BYPASS=1, a same-cycle clearing write to that address forces rd_busy[p] to 0 unless a same-cycle sb_set targets it.
- Reset asserted mid-operation clears all state immediately. Writes and sets presented during reset are lost.

## Timing
- Read latency is 0 cycles, whether from storage or from bypass. Write-to-read latency is 1 edge without bypass and 0 with bypass.
- sb_set becomes visible in busy_vec/rd_busy after 1 edge. A clear is visible after 1 edge, or in the same cycle through bypass.
- There are no handshakes. Every enabled input is consumed on the edge where it is sampled, and throughput is 2 writes plus 1 scoreboard set per cycle.
- Out-of-range parameters (NUM_RD > 4, NUM_REGS not a power of two) fail elaboration with $error.

## Structure
- Package regfile_pkg holds:
  - DEFAULT_DATA_W = 32 and DEFAULT_NUM_REGS = 32;
  - the write-port index constants WP0 = 0 and WP1 = 1;
  - a packed struct wr_req_t {en, clr, addr, data} used by the write ports at integration.
- Sub-module regfile_scoreboard holds the busy flops and the set/clear priority logic, and exports busy_vec. The storage array, write muxing, bypass and zero handling stay in regfile_mp.

## Test plan
- Reset: assert reset mid-run after writing 0xDEADBEEF to r5. Require rd_data = 0 and busy_vec = 0 while reset is held; after release, reading r5 returns 0.
- Dual write plus collision: port 0 writes r3=0x11 and port 1 writes r7=0x22 in one cycle, then r3 reads 0x11 and r7 reads 0x22. Next, both ports write r9 (0xAA on port 0, 0xBB on port 1) and r9 must read 0xBB.
- Bypass: port 1 writes r4=0x1234 while rd_addr[0]=4. Require rd_data[0]=0x1234 in the same cycle with BYPASS=1. With BYPASS=0, require the old value that cycle and 0x1234 on the next cycle.
- Zero register: write r0=0xFFFFFFFF and sb_set on r0. Require rd_data=0 for address 0 in the same and following cycles, and busy_vec[0]=0.
- Scoreboard: sb_set r6, so busy_vec[6]=1 on the next cycle. Then issue a port-0 write to r6 with wr_clr while also sb_set r6, and busy_vec[6] must stay 1. A later clearing write to r6 without sb_set gives busy 0, and rd_busy reads 0 in the same cycle via bypass.
- Parameter sweep: with NUM_RD=4, NUM_REGS=16, DATA_W=64, randomise 10k cycles of writes, reads and scoreboard traffic. Require a match against a reference model on every cycle.
